// File: rtl/step_scheduler.sv
// Wishbone-programmed stepper step scheduler: queued moves {interval, count, add, dir} become
// step/dir pulses timed against the free-running clock counter, with a signed position count.
module step_scheduler #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PULSE_TICKS = 4,
    parameter int unsigned DIR_SETUP   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] counter,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        step,
    output logic        dir,
    output logic        busy
);
    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LvlW   = PtrW + 1;
    localparam int unsigned TickW  = $clog2(PULSE_TICKS + 1);
    localparam int unsigned SetupW = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StWait  = 2'd2,
        StPulse = 2'd3
    } state_e;

    state_e              state_q;
    logic                step_q;
    logic                dir_q;
    logic [TickW-1:0]    hi_q;
    logic [TickW-1:0]    low_q;
    logic [SetupW-1:0]   setup_q;
    logic                enable_q;
    logic                overflow_q;
    logic [31:0]         position_q;
    logic [31:0]         last_time_q;
    logic [31:0]         next_time_q;
    logic [31:0]         iv_hold_q;
    logic [31:0]         mv_iv_q;
    logic [15:0]         mv_cnt_q;
    logic [14:0]         mv_add_q;
    logic                mv_dir_q;

    logic [31:0]         fifo_iv_q  [FIFO_DEPTH];
    logic [15:0]         fifo_cnt_q [FIFO_DEPTH];
    logic [14:0]         fifo_add_q [FIFO_DEPTH];
    logic                fifo_dir_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [LvlW-1:0]     level_q;

    logic                wr_en;
    logic                push_req;
    logic                flush;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pulse_end;
    logic [31:0]         due_diff;
    logic                due;
    logic                fire;
    logic                pop;
    logic                push_ok;
    logic [3:0]          lvl_rd;

    always_comb begin
        wr_en      = wb_cyc_i && wb_stb_i && wb_we_i;
        push_req   = wr_en && (wb_adr_i == 4'd1) && (wb_dat_i[15:0] != 16'd0);
        flush      = wr_en && (wb_adr_i == 4'd3) && wb_dat_i[1];
        fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
        fifo_empty = (level_q == '0);
        pulse_end  = step_q && (hi_q == '0);
        // Signed difference keeps the due test correct across counter wrap.
        due_diff   = counter - next_time_q;
        due        = !due_diff[31];
        fire       = (state_q == StWait) && due && (setup_q == '0) && (low_q == '0) && !step_q;
        pop        = !flush && enable_q && !fifo_empty &&
                     ((state_q == StIdle) ||
                      ((state_q == StPulse) && pulse_end && (mv_cnt_q == 16'd0)));
        push_ok    = push_req && (!fifo_full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_ok && !pop) begin
                level_q <= level_q + LvlW'(1);
            end else if (pop && !push_ok) begin
                level_q <= level_q - LvlW'(1);
            end
            if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_iv_q[wr_ptr_q]  <= iv_hold_q;
            fifo_cnt_q[wr_ptr_q] <= wb_dat_i[15:0];
            fifo_add_q[wr_ptr_q] <= wb_dat_i[30:16];
            fifo_dir_q[wr_ptr_q] <= wb_dat_i[31];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            hi_q        <= '0;
            low_q       <= '0;
            setup_q     <= '0;
            enable_q    <= 1'b0;
            position_q  <= 32'd0;
            last_time_q <= 32'd0;
            next_time_q <= 32'd0;
            iv_hold_q   <= 32'd0;
            mv_iv_q     <= 32'd0;
            mv_cnt_q    <= 16'd0;
            mv_add_q    <= 15'd0;
            mv_dir_q    <= 1'b0;
        end else begin
            // Pulse timing runs independently so a flush never truncates a high phase.
            if (step_q) begin
                if (hi_q == '0) begin
                    step_q <= 1'b0;
                    low_q  <= TickW'(PULSE_TICKS - 1);
                end else begin
                    hi_q <= hi_q - TickW'(1);
                end
            end else if (low_q != '0) begin
                low_q <= low_q - TickW'(1);
            end
            if (setup_q != '0) setup_q <= setup_q - SetupW'(1);

            if (flush) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (pop) begin
                            mv_iv_q  <= fifo_iv_q[rd_ptr_q];
                            mv_cnt_q <= fifo_cnt_q[rd_ptr_q];
                            mv_add_q <= fifo_add_q[rd_ptr_q];
                            mv_dir_q <= fifo_dir_q[rd_ptr_q];
                            state_q  <= StLoad;
                        end
                    end
                    StLoad: begin
                        next_time_q <= last_time_q + mv_iv_q;
                        if (mv_dir_q != dir_q) begin
                            dir_q   <= mv_dir_q;
                            setup_q <= SetupW'(DIR_SETUP);
                        end
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (fire) begin
                            step_q      <= 1'b1;
                            hi_q        <= TickW'(PULSE_TICKS - 1);
                            position_q  <= dir_q ? position_q - 32'd1 : position_q + 32'd1;
                            last_time_q <= next_time_q;
                            mv_cnt_q    <= mv_cnt_q - 16'd1;
                            mv_iv_q     <= mv_iv_q + {{17{mv_add_q[14]}}, mv_add_q};
                            state_q     <= StPulse;
                        end
                    end
                    StPulse: begin
                        if (pulse_end) begin
                            if (mv_cnt_q != 16'd0) begin
                                next_time_q <= last_time_q + mv_iv_q;
                                state_q     <= StWait;
                            end else if (pop) begin
                                mv_iv_q  <= fifo_iv_q[rd_ptr_q];
                                mv_cnt_q <= fifo_cnt_q[rd_ptr_q];
                                mv_add_q <= fifo_add_q[rd_ptr_q];
                                mv_dir_q <= fifo_dir_q[rd_ptr_q];
                                state_q  <= StLoad;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            // Software writes land last so they win over same-cycle updates.
            if (wr_en) begin
                case (wb_adr_i)
                    4'd0: iv_hold_q <= wb_dat_i;
                    4'd2: if (state_q == StIdle) last_time_q <= wb_dat_i;
                    4'd3: enable_q <= wb_dat_i[0];
                    4'd4: position_q <= wb_dat_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        lvl_rd = 4'(level_q);
        case (wb_adr_i)
            4'd0:    wb_dat_o = {overflow_q, 19'd0, lvl_rd, 2'd0, state_q, 3'd0, enable_q};
            4'd1:    wb_dat_o = position_q;
            4'd2:    wb_dat_o = last_time_q;
            default: wb_dat_o = 32'd0;
        endcase
    end

    assign wb_ack_o = 1'b1;
    assign step     = step_q;
    assign dir      = dir_q;
    assign busy     = (state_q != StIdle) || (level_q != '0);

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: directed timing scenarios plus randomized moves
// compared against a move-list model of scheduled step times, directions and position.
module tb_step_scheduler;
    localparam int unsigned Depth = 4;
    localparam int unsigned Ticks = 4;
    localparam int unsigned Setup = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] counter = 32'd0;
    logic        ctr_load = 1'b0;
    logic [31:0] ctr_val = 32'd0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = 4'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        step;
    logic        dir;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    step_scheduler #(
        .FIFO_DEPTH (Depth),
        .PULSE_TICKS(Ticks),
        .DIR_SETUP  (Setup)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .counter (counter),
        .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_we_i (wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .step    (step),
        .dir     (dir),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        counter <= ctr_load ? ctr_val : counter + 32'd1;
        cyc     <= cyc + 1;
    end

    // Monitor: rise time is the counter value the DUT compared on the rising edge.
    logic [31:0] rise_t[$];
    logic        rise_d[$];
    int          hi_len[$];
    int          low_gap[$];
    int          dir_gap[$];
    logic        step_prev = 1'b0;
    logic        dir_prev = 1'b0;
    int          rise_cyc = 0;
    int          fall_cyc = -1000;
    int          dir_cyc = -1000;

    always @(negedge clk) begin
        if (dir !== dir_prev) dir_cyc = cyc;
        if (step && !step_prev) begin
            rise_t.push_back(counter - 32'd1);
            rise_d.push_back(dir);
            low_gap.push_back(cyc - fall_cyc);
            dir_gap.push_back(cyc - dir_cyc);
            rise_cyc = cyc;
        end
        if (!step && step_prev) begin
            hi_len.push_back(cyc - rise_cyc);
            fall_cyc = cyc;
        end
        step_prev = step;
        dir_prev  = dir;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = a;
        wb_dat_i = d;
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        wb_adr_i = a;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        #1;
        d = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic set_counter(input logic [31:0] v);
        @(negedge clk);
        ctr_load = 1'b1;
        ctr_val  = v;
        @(negedge clk);
        ctr_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq({tag, "/idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Move list for the next run and the model's running state.
    logic [31:0] m_iv[8];
    int          m_cnt[8];
    int          m_add[8];
    int          m_dir[8];
    logic [31:0] model_pos = 32'd0;
    logic        model_dir = 1'b0;
    logic [31:0] en_ctr = 32'd0;

    task automatic run_moves(input string tag, input logic [31:0] lt_arg, input bit rel,
                             input int n, input bit exact);
        logic [31:0] lt;
        logic [31:0] t;
        logic [31:0] iv;
        logic [31:0] rd;
        logic [31:0] diff;
        logic [31:0] sched[$];
        logic        edir[$];
        rise_t.delete();
        rise_d.delete();
        hi_len.delete();
        low_gap.delete();
        dir_gap.delete();
        for (int k = 0; k < n; k++) begin
            wb_write(4'd0, m_iv[k]);
            wb_write(4'd1, {m_dir[k][0], 15'(m_add[k]), 16'(m_cnt[k])});
        end
        wb_read(4'd0, rd);
        check_eq({tag, "/level"}, {28'd0, rd[11:8]}, 32'(n));
        lt = rel ? counter + lt_arg : lt_arg;
        wb_write(4'd2, lt);
        en_ctr = counter;
        wb_write(4'd3, 32'd1);
        t = lt;
        for (int k = 0; k < n; k++) begin
            iv = m_iv[k];
            for (int c = 0; c < m_cnt[k]; c++) begin
                t = t + iv;
                sched.push_back(t);
                edir.push_back(m_dir[k][0]);
                model_pos = m_dir[k][0] ? model_pos - 32'd1 : model_pos + 32'd1;
                iv = iv + 32'(m_add[k]);
            end
            model_dir = m_dir[k][0];
        end
        wait_idle(tag, 6000);
        repeat (2) @(negedge clk);
        wb_write(4'd3, 32'd0);
        check_eq({tag, "/nrise"}, 32'(rise_t.size()), 32'(sched.size()));
        check_eq({tag, "/nhigh"}, 32'(hi_len.size()), 32'(sched.size()));
        for (int i = 0; i < sched.size() && i < rise_t.size(); i++) begin
            if (exact) begin
                check_eq({tag, "/rise_time"}, rise_t[i], sched[i]);
            end else begin
                diff = rise_t[i] - sched[i];
                check_eq({tag, "/not_early"}, {31'd0, ~diff[31]}, 32'd1);
            end
            check_eq({tag, "/rise_dir"}, {31'd0, rise_d[i]}, {31'd0, edir[i]});
            check_eq({tag, "/low_time"}, {31'd0, low_gap[i] >= int'(Ticks)}, 32'd1);
            check_eq({tag, "/dir_setup"}, {31'd0, dir_gap[i] >= int'(Setup)}, 32'd1);
            if (i < hi_len.size()) check_eq({tag, "/high_time"}, 32'(hi_len[i]), Ticks);
        end
        wb_read(4'd1, rd);
        check_eq({tag, "/position"}, rd, model_pos);
        wb_read(4'd2, rd);
        check_eq({tag, "/last_time"}, rd, t);
        wb_read(4'd0, rd);
        check_eq({tag, "/status"}, rd, 32'd0);
        check_eq({tag, "/dir_out"}, {31'd0, dir}, {31'd0, model_dir});
    endtask

    initial begin
        logic [31:0] rd;
        int          nm;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset/step", {31'd0, step}, 32'd0);
        check_eq("reset/dir", {31'd0, dir}, 32'd0);
        check_eq("reset/busy", {31'd0, busy}, 32'd0);
        check_eq("reset/ack", {31'd0, wb_ack_o}, 32'd1);
        wb_read(4'd0, rd);
        check_eq("reset/status", rd, 32'd0);
        wb_read(4'd1, rd);
        check_eq("reset/position", rd, 32'd0);
        wb_read(4'd2, rd);
        check_eq("reset/last_time", rd, 32'd0);
        wb_read(4'd7, rd);
        check_eq("reset/unmapped", rd, 32'd0);

        m_iv[0] = 32'd100; m_cnt[0] = 3; m_add[0] = 0; m_dir[0] = 0;
        run_moves("basic", 32'd1000, 1'b0, 1, 1'b1);

        set_counter(32'd0);
        m_iv[0] = 32'd200; m_cnt[0] = 3; m_add[0] = -50; m_dir[0] = 0;
        run_moves("accel", 32'd0, 1'b0, 1, 1'b1);

        wb_write(4'd4, 32'd0);
        model_pos = 32'd0;
        m_iv[0] = 32'd40; m_cnt[0] = 1; m_add[0] = 0; m_dir[0] = 0;
        m_iv[1] = 32'd2;  m_cnt[1] = 2; m_add[1] = 0; m_dir[1] = 1;
        run_moves("dirchg", 32'd10, 1'b1, 2, 1'b0);
        check_eq("dirchg/final_pos", model_pos, 32'hFFFF_FFFF);

        for (int k = 0; k < 5; k++) begin
            wb_write(4'd0, 32'd50);
            wb_write(4'd1, 32'd1);
        end
        wb_read(4'd0, rd);
        check_eq("ovf/level", {28'd0, rd[11:8]}, Depth);
        check_eq("ovf/flag", {31'd0, rd[31]}, 32'd1);
        check_eq("ovf/busy", {31'd0, busy}, 32'd1);
        wb_write(4'd1, 32'd0);
        wb_read(4'd0, rd);
        check_eq("ovf/zero_count_push", {28'd0, rd[11:8]}, Depth);
        wb_write(4'd3, 32'd2);
        wb_read(4'd0, rd);
        check_eq("flush/level", {28'd0, rd[11:8]}, 32'd0);
        check_eq("flush/flag", {31'd0, rd[31]}, 32'd0);
        check_eq("flush/busy", {31'd0, busy}, 32'd0);

        set_counter(32'hFFFF_FFB0);
        m_iv[0] = 32'h20; m_cnt[0] = 1; m_add[0] = 0; m_dir[0] = int'(model_dir);
        run_moves("wrap", 32'hFFFF_FFF0, 1'b0, 1, 1'b1);

        m_iv[0] = 32'd10; m_cnt[0] = 2; m_add[0] = 0; m_dir[0] = int'(model_dir);
        run_moves("late", 32'hFFFF_FC18, 1'b1, 1, 1'b0);
        if (rise_t.size() > 0) begin
            check_eq("late/immediate", {31'd0, (rise_t[0] - en_ctr) <= 32'd8}, 32'd1);
        end

        for (int r = 0; r < 6; r++) begin
            nm = int'($urandom_range(Depth, 1));
            for (int k = 0; k < nm; k++) begin
                m_iv[k]  = $urandom_range(100, 40);
                m_cnt[k] = int'($urandom_range(4, 1));
                m_add[k] = int'($urandom_range(6, 0)) - 3;
                m_dir[k] = int'($urandom_range(1, 0));
            end
            run_moves("random", 32'd30, 1'b1, nm, 1'b1);
        end

        wb_write(4'd0, 32'd30);
        wb_write(4'd1, 32'd10);
        wb_write(4'd1, 32'd2);
        wb_write(4'd2, counter);
        wb_write(4'd3, 32'd1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (step) break;
        end
        check_eq("rstpulse/step_seen", {31'd0, step}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstpulse/step", {31'd0, step}, 32'd0);
        check_eq("rstpulse/busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wb_read(4'd0, rd);
        check_eq("rstpulse/status", rd, 32'd0);
        wb_read(4'd1, rd);
        check_eq("rstpulse/position", rd, 32'd0);
        wb_read(4'd2, rd);
        check_eq("rstpulse/last_time", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
